// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM state type and default geometry for the systolic array and its skew/deskew stages
// Contents: state_t (IDLE/STREAM/DRAIN/DONE), ARRAY_N_DEF, INP_DATA_WIDTH_DEF
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  localparam int ARRAY_N_DEF        = 32;
  localparam int INP_DATA_WIDTH_DEF = 8;
endpackage

// File: rtl/systolic_inp_skew_delay_line.sv
// skew_delay_line: DEPTH-stage register chain carrying one lane element plus its valid bit
// Ports: clk, rst (sync active-high), in_data/in_valid (chain head), out_data/out_valid (chain tail)
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);
  logic [WIDTH-1:0] d [DEPTH];
  logic             v [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
        v[i] <= 1'b0;
      end
    end else begin
      d[0] <= in_data;
      v[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        d[i] <= d[i-1];
        v[i] <= v[i-1];
      end
    end
  end
  assign out_data  = d[DEPTH-1];
  assign out_valid = v[DEPTH-1];
endmodule

// File: rtl/systolic_inp_skew.sv
// systolic_inp_skew: skews input vectors so lane k reaches the array top row k+1 cycles after accept
// Ports: clk, rst (sync active-high); in_valid/in_ready/in_data/in_last (upstream handshake);
//        out_data/out_valid (per-lane skewed stream); busy, done (burst end pulse), vec_cnt (accepted vectors)
module systolic_inp_skew
  import systolic_pkg::*;
#(
  parameter int ARRAY_N        = ARRAY_N_DEF,
  parameter int INP_DATA_WIDTH = INP_DATA_WIDTH_DEF,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ARRAY_N*INP_DATA_WIDTH-1:0] in_data,
  input  logic                              in_last,
  output logic [ARRAY_N*INP_DATA_WIDTH-1:0] out_data,
  output logic [ARRAY_N-1:0]                out_valid,
  output logic                              busy,
  output logic                              done,
  output logic [CNT_WIDTH-1:0]              vec_cnt
);
  // Width kept at 1 for ARRAY_N=1, where DRAIN is never entered.
  localparam int DCW = ARRAY_N > 1 ? $clog2(ARRAY_N) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(ARRAY_N > 1 ? ARRAY_N - 2 : 0);
  state_t         state;
  logic [DCW-1:0] drain_cnt;
  logic           acc;
  assign acc = in_valid && in_ready;
  // Outputs are registered: busy/in_ready/done change together with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      done      <= 1'b0;
      drain_cnt <= '0;
      vec_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, STREAM: begin
          if (acc) begin
            vec_cnt <= state == IDLE ? CNT_WIDTH'(1) : (&vec_cnt ? vec_cnt : vec_cnt + 1'b1);
            busy    <= 1'b1;
            if (in_last) begin
              in_ready  <= 1'b0;
              drain_cnt <= '0;
              state     <= ARRAY_N == 1 ? DONE : DRAIN;
              done      <= ARRAY_N == 1;
            end else begin
              state <= STREAM;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
  // Idle cycles inject a zero bubble so later elements keep their diagonal alignment.
  for (genvar k = 0; k < ARRAY_N; k++) begin : g_lane
    skew_delay_line #(
      .DEPTH(k + 1),
      .WIDTH(INP_DATA_WIDTH)
    ) u_line (
      .clk      (clk),
      .rst      (rst),
      .in_data  (acc ? in_data[k*INP_DATA_WIDTH +: INP_DATA_WIDTH] : '0),
      .in_valid (acc),
      .out_data (out_data[k*INP_DATA_WIDTH +: INP_DATA_WIDTH]),
      .out_valid(out_valid[k])
    );
  end
endmodule

// File: tb/tb_systolic_inp_skew.sv
// tb_systolic_inp_skew: scoreboard bench for systolic_inp_skew (ARRAY_N=4, 8-bit lanes, plus a CNT_WIDTH=2 copy)
module tb_systolic_inp_skew;
  localparam int N = 4;
  localparam int W = 8;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic           in_ready, busy, done;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [15:0]    vec_cnt;
  logic           in_ready2, busy2, done2;
  logic [N*W-1:0] out_data2;
  logic [N-1:0]   out_valid2;
  logic [1:0]     vec_cnt2;
  systolic_inp_skew #(.ARRAY_N(N), .INP_DATA_WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_data(out_data), .out_valid(out_valid), .busy(busy),
    .done(done), .vec_cnt(vec_cnt)
  );
  systolic_inp_skew #(.ARRAY_N(N), .INP_DATA_WIDTH(W), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_last(in_last), .out_data(out_data2), .out_valid(out_valid2), .busy(busy2),
    .done(done2), .vec_cnt(vec_cnt2)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int lq [N][$];
  int dq [$];
  bit m_stream = 0;
  bit m_lv = 0;
  int m_last = 0;
  int m_cnt = 0;
  int m_cnt2 = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
  endtask
  function automatic bit m_drain(int c);
    return m_lv && c > m_last && c <= m_last + N;
  endfunction
  task automatic step(bit v, bit l, logic [N*W-1:0] d, bit r);
    bit acc;
    int c;
    bit ev;
    logic [7:0] ed;
    rst = r;
    in_valid = v;
    in_last = l;
    in_data = d;
    c = cyc;
    acc = !r && v && !m_drain(c);
    @(posedge clk);
    cyc++;
    if (r) begin
      for (int k = 0; k < N; k++) lq[k].delete();
      dq.delete();
      m_stream = 0;
      m_lv = 0;
      m_cnt = 0;
      m_cnt2 = 0;
    end else if (acc) begin
      for (int k = 0; k < N; k++) lq[k].push_back(((c + 1 + k) << 8) | int'(d[k*W +: W]));
      m_cnt  = m_stream ? (m_cnt == 65535 ? m_cnt : m_cnt + 1) : 1;
      m_cnt2 = m_stream ? (m_cnt2 == 3 ? m_cnt2 : m_cnt2 + 1) : 1;
      if (l) begin
        m_stream = 0;
        m_lv = 1;
        m_last = c;
        dq.push_back(c + N);
      end else begin
        m_stream = 1;
      end
    end
    #1;
    for (int k = 0; k < N; k++) begin
      ev = lq[k].size() > 0 && (lq[k][0] >> 8) == cyc;
      ed = ev ? 8'(lq[k][0] & 255) : 8'h00;
      if (ev) void'(lq[k].pop_front());
      chk($sformatf("lane%0d", k), {55'd0, out_valid[k], out_data[k*W +: W]}, {55'd0, ev, ed});
    end
    ev = dq.size() > 0 && dq[0] == cyc;
    if (ev) void'(dq.pop_front());
    chk("done", done, ev);
    chk("done_sat", done2, ev);
    chk("in_ready", in_ready, !m_drain(cyc));
    chk("busy", busy, m_stream || m_drain(cyc));
    chk("vec_cnt", vec_cnt, m_cnt);
    chk("vec_cnt_sat", vec_cnt2, m_cnt2);
  endtask
  function automatic logic [N*W-1:0] rnd_vec();
    return {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
  endfunction
  initial begin
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 0);
    step(1, 1, 32'h44332211, 0);
    repeat (6) step(0, 0, '0, 0);
    step(1, 0, 32'hA1A2A3A4, 0);
    step(1, 0, 32'hB1B2B3B4, 0);
    step(1, 1, 32'hC1C2C3C4, 0);
    repeat (N + 2) step(1, 1, 32'hD5D6D7D8, 0);
    repeat (6) step(0, 0, '0, 0);
    step(1, 0, 32'h0F0E0D0C, 0);
    step(0, 0, 32'hFFFFFFFF, 0);
    step(1, 1, 32'h80402010, 0);
    repeat (6) step(0, 0, '0, 0);
    step(1, 0, 32'h11111111, 0);
    step(1, 0, 32'h22222222, 0);
    step(1, 0, 32'h33333333, 1);
    repeat (6) step(0, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(1, i == 4, rnd_vec(), 0);
    repeat (6) step(0, 0, '0, 0);
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, rnd_vec(), $urandom_range(0, 39) == 0);
    repeat (6) step(0, 0, '0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
